// File: rtl/logical_pkg.sv
// Shared types for the logical-unit arbiter: LU opcodes, arbiter FSM states and the LU instruction width.
package logical_pkg;

  localparam int LU_INSTR_W = 3;

  typedef enum logic [LU_INSTR_W-1:0] {
    LOP_AND  = 3'd0,
    LOP_OR   = 3'd1,
    LOP_XOR  = 3'd2,
    LOP_NOR  = 3'd3,
    LOP_NAND = 3'd4,
    LOP_XNOR = 3'd5,
    LOP_GT   = 3'd6,
    LOP_EQ   = 3'd7
  } lop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/logical_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above the pointer, wrapping at NREQ.
module rr_pick
  import logical_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_j;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end else begin
        w_sum = w_sum;
      end
      w_j = w_sum[PW-1:0];
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/logical_arbiter.sv
// Round-robin arbiter sharing one combinational logical unit between NREQ valid/ready requesters.
module logical_arbiter
  import logical_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int N    = 4,
  parameter int M    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*N-1:0]     req_a,
  input  logic [NREQ*N-1:0]     req_b,
  input  logic [NREQ*(M-1)-1:0] req_instr,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [N-1:0]          rsp_data,
  output logic [N-1:0]          lu_a,
  output logic [N-1:0]          lu_b,
  output logic [M-2:0]          lu_instr,
  input  logic [N-1:0]          lu_out,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = M - 1;

  arb_state_e    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gidx;
  logic [N-1:0]  r_lu_a;
  logic [N-1:0]  r_lu_b;
  logic [IW-1:0] r_lu_instr;
  logic [N-1:0]  r_rsp_data;
  logic [NREQ-1:0] r_rsp_valid;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic            w_accept;
  logic [NREQ-1:0] w_gidx_oh;
  logic [N-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;
  logic [IW-1:0]   w_sel_instr;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grant is only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready   = '0;
    w_accept    = 1'b0;
    w_gidx_oh   = '0;
    w_sel_a     = req_a[w_idx*N +: N];
    w_sel_b     = req_b[w_idx*N +: N];
    w_sel_instr = req_instr[w_idx*IW +: IW];
    if (rst_n && (r_state == ST_IDLE)) begin
      req_ready = w_grant;
      w_accept  = w_any;
    end else begin
      req_ready = '0;
      w_accept  = 1'b0;
    end
    w_gidx_oh[r_gidx] = 1'b1;
  end

  // Arbiter FSM, operand capture and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_lu_a      <= '0;
      r_lu_b      <= '0;
      r_lu_instr  <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_lu_a     <= w_sel_a;
            r_lu_b     <= w_sel_b;
            r_lu_instr <= w_sel_instr;
            r_gidx     <= w_idx;
            r_ptr      <= (w_idx == PW'(NREQ-1)) ? '0 : w_idx + PW'(1);
            r_state    <= ST_EXEC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= lu_out;
          r_rsp_valid <= w_gidx_oh;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owning requester's ready can retire the response.
          if (rsp_ready[r_gidx]) begin
            r_rsp_valid <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign lu_a      = r_lu_a;
  assign lu_b      = r_lu_b;
  assign lu_instr  = r_lu_instr;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_logical_arbiter.sv
// Directed self-checking bench for logical_arbiter with NREQ=2, N=4 and a behavioural LU attached.
module tb_logical_arbiter;

  localparam int NREQ = 2;
  localparam int N    = 4;
  localparam int M    = 4;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ*(M-1)-1:0] req_instr;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready;
  logic [N-1:0]    rsp_data;
  logic [N-1:0]    lu_a;
  logic [N-1:0]    lu_b;
  logic [M-2:0]    lu_instr;
  logic [N-1:0]    lu_out;
  logic            busy;

  int n_checks;
  int n_errors;

  logical_arbiter #(.NREQ(NREQ), .N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_instr (req_instr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_instr  (lu_instr),
    .lu_out    (lu_out),
    .busy      (busy)
  );

  // Behavioural logical unit sitting beside the arbiter.
  always_comb begin
    case (lu_instr)
      3'd0:    lu_out = lu_a & lu_b;
      3'd1:    lu_out = lu_a | lu_b;
      3'd2:    lu_out = lu_a ^ lu_b;
      3'd3:    lu_out = ~(lu_a | lu_b);
      3'd4:    lu_out = ~(lu_a & lu_b);
      3'd5:    lu_out = ~(lu_a ^ lu_b);
      3'd6:    lu_out = {3'b000, (lu_a > lu_b)};
      3'd7:    lu_out = {3'b000, (lu_a == lu_b)};
      default: lu_out = 4'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_a[i*N +: N]         = a;
    req_b[i*N +: N]         = b;
    req_instr[i*(M-1) +: 3] = op;
  endtask

  // One complete transaction from a single requester with latency checks.
  task automatic do_op(input string tag, input int i, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] exp);
    logic [1:0] oh;
    oh = 2'b01 << i;
    set_req(i, a, b, op);
    req_valid = oh;
    #1 check_val({tag, "_ready"}, 32'(req_ready), 32'(oh));
    step();
    req_valid = 2'b00;
    #1 check_val({tag, "_t1_valid"}, 32'(rsp_valid), 32'h0);
    step();
    check_val({tag, "_t2_valid"}, 32'(rsp_valid), 32'(oh));
    check_val({tag, "_data"}, 32'(rsp_data), 32'(exp));
    rsp_ready = oh;
    step();
    rsp_ready = 2'b00;
    check_val({tag, "_done_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = 2'b01;
    req_a     = '0;
    req_b     = '0;
    req_instr = '0;
    rsp_ready = 2'b00;
    step();
    step();
    #1;
    check_val("rst_req_ready", 32'(req_ready), 32'h0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_rsp_data", 32'(rsp_data), 32'h0);
    check_val("rst_lu_a", 32'(lu_a), 32'h0);
    check_val("rst_lu_instr", 32'(lu_instr), 32'h0);
    req_valid = 2'b00;

    // Test 1: single AND op with operand hold checks.
    step();
    rst_n = 1'b1;
    set_req(0, 4'hC, 4'hA, 3'd0);
    req_valid = 2'b01;
    #1 check_val("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00;
    #1;
    check_val("t1_busy", 32'(busy), 32'h1);
    check_val("t1_lu_a", 32'(lu_a), 32'hC);
    check_val("t1_lu_b", 32'(lu_b), 32'hA);
    check_val("t1_exec_ready", 32'(req_ready), 32'h0);
    check_val("t1_exec_valid", 32'(rsp_valid), 32'h0);
    step();
    check_val("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_val("t1_rsp_data", 32'(rsp_data), 32'h8);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    check_val("t1_idle_valid", 32'(rsp_valid), 32'h0);
    check_val("t1_idle_busy", 32'(busy), 32'h0);
    check_val("t1_data_hold", 32'(rsp_data), 32'h8);

    // Test 2: contention from reset, pointer must alternate 0,1,0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(0, 4'hC, 4'h3, 3'd1);
    set_req(1, 4'hC, 4'hA, 3'd2);
    req_valid = 2'b11;
    #1 check_val("t2_grant0", 32'(req_ready), 32'h1);
    step();
    step();
    check_val("t2_rsp0_valid", 32'(rsp_valid), 32'h1);
    check_val("t2_rsp0_data", 32'(rsp_data), 32'hF);
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b00;
    #1 check_val("t2_grant1", 32'(req_ready), 32'h2);
    step();
    step();
    check_val("t2_rsp1_valid", 32'(rsp_valid), 32'h2);
    check_val("t2_rsp1_data", 32'(rsp_data), 32'h6);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    #1 check_val("t2_grant0_again", 32'(req_ready), 32'h1);

    // Test 3: response backpressure on requester 0.
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_val("t3_hold_valid", 32'(rsp_valid), 32'h1);
      check_val("t3_hold_data", 32'(rsp_data), 32'hF);
      check_val("t3_hold_ready", 32'(req_ready), 32'h0);
      check_val("t3_hold_busy", 32'(busy), 32'h1);
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    check_val("t3_release_busy", 32'(busy), 32'h0);
    check_val("t3_release_valid", 32'(rsp_valid), 32'h0);

    // Test 4: compare and NOR ops across both requesters.
    do_op("t4_gt_true", 1, 4'h5, 4'h3, 3'd6, 4'h1);
    do_op("t4_gt_false", 0, 4'h3, 4'h5, 3'd6, 4'h0);
    do_op("t4_eq", 1, 4'h7, 4'h7, 3'd7, 4'h1);
    do_op("t4_nor", 0, 4'h0, 4'hF, 3'd3, 4'h0);
    do_op("t4_xnor", 1, 4'h9, 4'h3, 3'd5, 4'h5);

    // Test 5: reset during EXEC drops the op and clears the pointer.
    set_req(0, 4'hF, 4'hF, 3'd4);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    rst_n = 1'b0;
    step();
    #1;
    check_val("t5_valid", 32'(rsp_valid), 32'h0);
    check_val("t5_busy", 32'(busy), 32'h0);
    check_val("t5_ready_in_rst", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1 check_val("t5_ptr0", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    step();
    step();
    check_val("t5_no_rsp", 32'(rsp_valid), 32'h0);

    // Test 6: only the owning requester's rsp_ready retires the response.
    set_req(1, 4'h3, 4'h5, 3'd0);
    req_valid = 2'b10;
    #1 check_val("t6_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    step();
    check_val("t6_valid", 32'(rsp_valid), 32'h2);
    check_val("t6_data", 32'(rsp_data), 32'h1);
    rsp_ready = 2'b01;
    step();
    check_val("t6_wrong_ready_valid", 32'(rsp_valid), 32'h2);
    check_val("t6_wrong_ready_busy", 32'(busy), 32'h1);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    check_val("t6_exit_valid", 32'(rsp_valid), 32'h0);
    check_val("t6_exit_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
